// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit common-anode 7-segment scan driver
// Loaded data is held pending and only committed on a frame boundary so a frame never tears.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DIV_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg7,
    output logic                    pending,
    output logic                    frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_value_q, pend_value_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
    logic                    pend_lz_q, pend_lz_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] com_value_q, com_value_d;
    logic [NUM_DIGITS-1:0]   com_en_q, com_en_d;
    logic                    com_lz_q, com_lz_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg7_q, seg7_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                    last_slot;
    logic                    boundary;
    logic                    commit;
    logic [NUM_DIGITS-1:0]   upper_zero;
    logic                    all_zero;
    logic [3:0]              cur_nib;
    logic                    cur_dark;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        last_slot = (cnt_q == CNT_LAST);
        boundary  = last_slot && (idx_q == IDX_LAST);
        commit    = boundary && pending_q;

        cnt_d = last_slot ? '0 : cnt_q + DIV_W'(1);
        idx_d = idx_q;
        if (last_slot) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        pend_value_d = load ? value    : pend_value_q;
        pend_en_d    = load ? digit_en : pend_en_q;
        pend_lz_d    = load ? lz_blank : pend_lz_q;
        pending_d    = load ? 1'b1 : (commit ? 1'b0 : pending_q);

        com_value_d = commit ? pend_value_q : com_value_q;
        com_en_d    = commit ? pend_en_q    : com_en_q;
        com_lz_d    = commit ? pend_lz_q    : com_lz_q;

        frame_tick_d = boundary;
    end

    // upper_zero[i] = nibbles i..NUM_DIGITS-1 of the committed value are all zero
    always_comb begin
        upper_zero = '0;
        all_zero   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero      = all_zero && (com_value_q[4*i +: 4] == 4'h0);
            upper_zero[i] = all_zero;
        end
    end

    always_comb begin
        cur_nib  = 4'h0;
        cur_dark = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib  = com_value_q[4*i +: 4];
                cur_dark = !com_en_q[i] || (com_lz_q && (i != 0) && upper_zero[i]);
            end
        end

        an_d   = '1;
        seg7_d = 7'b1111111;
        if (!cur_dark) begin
            seg7_d = decode(cur_nib);
            // the first cycle of each slot keeps all anodes off to avoid ghosting
            if (cnt_q != '0) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        an_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_value_q <= '0;
            pend_en_q    <= '0;
            pend_lz_q    <= 1'b0;
            pending_q    <= 1'b0;
            com_value_q  <= '0;
            com_en_q     <= '0;
            com_lz_q     <= 1'b0;
            an_q         <= '1;
            seg7_q       <= 7'b1111111;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_value_q <= pend_value_d;
            pend_en_q    <= pend_en_d;
            pend_lz_q    <= pend_lz_d;
            pending_q    <= pending_d;
            com_value_q  <= com_value_d;
            com_en_q     <= com_en_d;
            com_lz_q     <= com_lz_d;
            an_q         <= an_d;
            seg7_q       <= seg7_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg7       = seg7_q;
    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver (4 digits, 4 cycles per slot)
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [15:0]   value;
    logic [3:0]    digit_en;
    logic          lz_blank;
    logic [3:0]    an;
    logic [6:0]    seg7;
    logic          pending;
    logic          frame_tick;

    seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .digit_en(digit_en),
        .lz_blank(lz_blank), .an(an), .seg7(seg7), .pending(pending), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       seg_valid;
        logic       pend;
        logic       ft;
    } exp_t;

    exp_t sb[$];

    logic [6:0] dec_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int         m_cnt, m_idx;
    logic [15:0] m_pv, m_cv;
    logic [3:0]  m_pe, m_ce;
    logic        m_pl, m_cl, m_pend;

    int errors = 0;
    int checks = 0;
    int seen_one = 0;
    int frame_ticks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_idx = 0;
        m_pv = '0; m_pe = '0; m_pl = 1'b0; m_pend = 1'b0;
        m_cv = '0; m_ce = '0; m_cl = 1'b0;
    endtask

    task automatic tick();
        exp_t e, g;
        logic bnd, dark;
        logic [15:0] upper;
        if (rst) begin
            e.an = 4'hF; e.seg = 7'h7F; e.seg_valid = 1'b1; e.pend = 1'b0; e.ft = 1'b0;
            model_reset();
        end else begin
            bnd   = (m_cnt == RD - 1) && (m_idx == ND - 1);
            upper = m_cv >> (4 * m_idx);
            dark  = !m_ce[m_idx] || (m_cl && m_idx != 0 && upper == 16'h0);
            e.ft  = bnd;
            if (dark) begin
                e.an = 4'hF; e.seg = 7'h7F; e.seg_valid = 1'b1;
            end else begin
                e.seg = dec_tab[upper[3:0]];
                e.seg_valid = (m_cnt != 0);
                e.an = (m_cnt == 0) ? 4'hF : ~(4'b0001 << m_idx);
            end
            if (bnd && m_pend) begin
                m_cv = m_pv; m_ce = m_pe; m_cl = m_pl; m_pend = 1'b0;
            end
            if (load) begin
                m_pv = value; m_pe = digit_en; m_pl = lz_blank; m_pend = 1'b1;
            end
            if (m_cnt == RD - 1) begin
                m_cnt = 0;
                m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
            end else begin
                m_cnt++;
            end
            e.pend = m_pend;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("an", {28'b0, an}, {28'b0, g.an});
        if (g.seg_valid) check("seg7", {25'b0, seg7}, {25'b0, g.seg});
        check("pending", {31'b0, pending}, {31'b0, g.pend});
        check("frame_tick", {31'b0, frame_tick}, {31'b0, g.ft});
        if (frame_tick) frame_ticks++;
        if (an != 4'hF && seg7 == 7'b1111001) seen_one++;
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic lz);
        value = v; digit_en = en; lz_blank = lz; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // advance until the next tick lands on the frame-boundary cycle
    task automatic to_boundary();
        int guard = 0;
        while (!(m_cnt == RD - 1 && m_idx == ND - 1) && guard < 32) begin
            tick();
            guard++;
        end
        check("to_boundary_bound", {31'b0, guard < 32}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; digit_en = '0; lz_blank = 1'b0;
        model_reset();
        @(posedge clk); #1;
        tick();
        tick();
        rst = 1'b0;

        // idle: dark display, frame_tick every 16 cycles
        step(48);
        check("idle_frame_ticks", frame_ticks, 3);

        // plain hex, loaded mid-frame
        step(5);
        do_load(16'h12AF, 4'hF, 1'b0);
        check("pending_after_load", {31'b0, pending}, 32'd1);
        step(40);

        // leading-zero blanking
        do_load(16'h0050, 4'hF, 1'b1);
        step(36);
        do_load(16'h0000, 4'hF, 1'b1);
        step(36);

        // last load before commit wins
        to_boundary();
        tick();
        seen_one = 0;
        do_load(16'h1111, 4'hF, 1'b0);
        step(2);
        do_load(16'h2222, 4'hF, 1'b0);
        step(36);
        check("no_1111_shown", seen_one, 0);

        // load on the boundary while another value is pending
        do_load(16'h4444, 4'hF, 1'b0);
        to_boundary();
        do_load(16'h3333, 4'hF, 1'b0);
        check("pending_kept_on_boundary", {31'b0, pending}, 32'd1);
        step(16);
        check("pending_until_next_boundary", {31'b0, pending}, 32'd0);
        step(16);

        // mid-slot reset clears everything; display stays dark
        step(6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_an", {28'b0, an}, 32'hF);
        check("rst_seg7", {25'b0, seg7}, 32'h7F);
        step(40);
        do_load(16'h9E07, 4'hB, 1'b0);
        step(40);

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
